rv_pl_watchdog: RTL

- Synthesizable run monitor that sits directly downstream of the rv_pl 5-stage core and consumes its fetch-PC and write-back signals.
- Counts run cycles and architectural register writes.
- Detects a stuck-PC condition (same fetch PC repeated without a stall) and a cycle-budget timeout, then raises a sticky halt request.
- Replaces simulation-only loop detection so the same check works on FPGA builds.

---
 rtl/rv_pl_watchdog_if.sv | 28 ++
 rtl/rv_pl_watchdog.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rv_pl_watchdog_if.sv
// Core-to-watchdog observation bus: fetch PC/stall and write-back port
// of the rv_pl 5-stage core. The core (or a bench) drives the master side,
// the watchdog listens on the slave side.
interface rv_pl_watchdog_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] f_pc;
    logic            f_stall;
    logic            w_we_rf;
    logic [4:0]      w_rf_a3;
    logic [31:0]     w_result;

    modport master (
        output f_pc,
        output f_stall,
        output w_we_rf,
        output w_rf_a3,
        output w_result
    );

    modport slave (
        input f_pc,
        input f_stall,
        input w_we_rf,
        input w_rf_a3,
        input w_result
    );
endinterface

// File: rtl/rv_pl_watchdog.sv
// rv_pl_watchdog: run monitor for the rv_pl core. Counts run cycles and
// register writes, flags a stuck fetch PC or an exhausted cycle budget and
// raises a sticky halt request that only clr or reset removes.
// Optional write history: define RV_PL_WDOG_HIST_EN to add a 4-entry
// circular record of (rd, data) pairs on hist_rd/hist_data.
module rv_pl_watchdog #(
    parameter int unsigned MAX_SAME_PC    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 30,
    parameter int          PC_W           = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    rv_pl_watchdog_if.slave      bus,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          wb_cnt,
    output logic                 stuck,
    output logic                 timeout,
    output logic [PC_W-1:0]      stuck_pc,
    output logic                 halt_req
`ifdef RV_PL_WDOG_HIST_EN
    ,
    output logic [19:0]          hist_rd,
    output logic [127:0]         hist_data
`endif
);

    localparam logic [7:0]  MAX_C = 8'(MAX_SAME_PC);
    localparam logic [31:0] TO_C  = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STUCK   = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       wb_q, wb_d;
    logic [7:0]        same_q, same_d;
    logic [PC_W-1:0]   last_pc_q, last_pc_d;
    logic              stuck_q, stuck_d;
    logic              timeout_q, timeout_d;
    logic [PC_W-1:0]   stuck_pc_q, stuck_pc_d;
    logic              halt_q, halt_d;
    logic              hit_stuck, hit_timeout;
    logic              wb_fire;

    // A register write is architecturally visible only in RUN and for rd != x0.
    assign wb_fire = (state_q == RUN) && bus.w_we_rf && (bus.w_rf_a3 != 5'd0);

    // Next-state logic: clr wins, IDLE is a one-cycle gap, RUN counts and
    // detects, STUCK/TIMEOUT freeze everything.
    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        wb_d        = wb_q;
        same_d      = same_q;
        last_pc_d   = last_pc_q;
        stuck_d     = stuck_q;
        timeout_d   = timeout_q;
        stuck_pc_d  = stuck_pc_q;
        hit_stuck   = 1'b0;
        hit_timeout = 1'b0;

        if (clr) begin
            state_d    = IDLE;
            cycle_d    = '0;
            wb_d       = '0;
            same_d     = '0;
            last_pc_d  = '1;
            stuck_d    = 1'b0;
            timeout_d  = 1'b0;
            stuck_pc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                end
                RUN: begin
                    cycle_d = cycle_q + 32'd1;
                    if (wb_fire) begin
                        wb_d = wb_q + 32'd1;
                    end
                    // A stall is a legitimate reason for the PC to repeat,
                    // so it restarts the repeat count.
                    if ((bus.f_pc == last_pc_q) && !bus.f_stall) begin
                        if (same_q != 8'hFF) begin
                            same_d = same_q + 8'd1;
                        end
                    end else begin
                        same_d    = '0;
                        last_pc_d = bus.f_pc;
                    end
                    hit_stuck   = (same_d == MAX_C);
                    hit_timeout = (cycle_d == TO_C);
                    if (hit_stuck) begin
                        state_d    = STUCK;
                        stuck_d    = 1'b1;
                        stuck_pc_d = bus.f_pc;
                    end
                    if (hit_timeout) begin
                        timeout_d = 1'b1;
                        if (!hit_stuck) begin
                            state_d = TIMEOUT;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
        halt_d = stuck_d | timeout_d;
    end

    // State and counter registers; halt is registered alongside the flags
    // so it rises in the same cycle they do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cycle_q    <= '0;
            wb_q       <= '0;
            same_q     <= '0;
            last_pc_q  <= '1;
            stuck_q    <= 1'b0;
            timeout_q  <= 1'b0;
            stuck_pc_q <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            wb_q       <= wb_d;
            same_q     <= same_d;
            last_pc_q  <= last_pc_d;
            stuck_q    <= stuck_d;
            timeout_q  <= timeout_d;
            stuck_pc_q <= stuck_pc_d;
            halt_q     <= halt_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign wb_cnt    = wb_q;
    assign stuck     = stuck_q;
    assign timeout   = timeout_q;
    assign stuck_pc  = stuck_pc_q;
    assign halt_req  = halt_q;

`ifdef RV_PL_WDOG_HIST_EN
    logic [3:0][4:0]  hist_rd_q, hist_rd_d;
    logic [3:0][31:0] hist_data_q, hist_data_d;
    logic [1:0]       hist_ptr_q, hist_ptr_d;

    // History ring: write at the pointer, pointer wraps naturally 3 -> 0.
    always_comb begin
        hist_rd_d   = hist_rd_q;
        hist_data_d = hist_data_q;
        hist_ptr_d  = hist_ptr_q;
        if (clr) begin
            hist_rd_d   = '0;
            hist_data_d = '0;
            hist_ptr_d  = '0;
        end else if (wb_fire) begin
            hist_rd_d[hist_ptr_q]   = bus.w_rf_a3;
            hist_data_d[hist_ptr_q] = bus.w_result;
            hist_ptr_d              = hist_ptr_q + 2'd1;
        end
    end

    // History storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_rd_q   <= '0;
            hist_data_q <= '0;
            hist_ptr_q  <= '0;
        end else begin
            hist_rd_q   <= hist_rd_d;
            hist_data_q <= hist_data_d;
            hist_ptr_q  <= hist_ptr_d;
        end
    end

    assign hist_rd   = hist_rd_q;
    assign hist_data = hist_data_q;
`else
    logic unused_result;
    assign unused_result = ^bus.w_result;
`endif

endmodule
